// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among N_REQ valid/ready producers.
// Optional FWA_BURST_LOCK_EN: hold the grant for a whole packet (up to MAX_BURST beats); otherwise one beat per grant.
module fifo_write_arbiter #(
  parameter  int N_REQ     = 4,
  parameter  int DSIZE     = 32,
  parameter  int MAX_BURST = 16,
  localparam int IDW       = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       in_valid,
  input  logic [N_REQ*DSIZE-1:0] in_data,
  input  logic [N_REQ-1:0]       in_last,
  output logic [N_REQ-1:0]       in_ready,
  output logic [DSIZE-1:0]       fifo_wdata,
  output logic                   fifo_winc,
  input  logic                   fifo_wfull,
  output logic                   gnt_valid,
  output logic [IDW-1:0]         gnt_id
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [CW-1:0]    beat_cnt;
  logic [N_REQ-1:0] gnt_onehot;

  logic [DSIZE-1:0] data_arr [N_REQ];
  logic [IDW-1:0]   scan_idx;
  logic [IDW-1:0]   pick_id;
  logic             pick_found;
  logic             cur_valid;
  logic             accept;
  logic             burst_done;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = in_data[gi*DSIZE +: DSIZE];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest valid requester after rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      scan_idx = IDW'((int'(rr_ptr) + k) % N_REQ);
      if (in_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

  assign cur_valid  = in_valid[gnt_id];
  assign accept     = (state == BURST) && cur_valid && !fifo_wfull;
  // gnt_onehot is zero outside BURST, so ready is a single AND with !fifo_wfull.
  assign in_ready   = gnt_onehot & {N_REQ{!fifo_wfull}};
  assign fifo_winc  = accept;
  assign fifo_wdata = (state == BURST) ? data_arr[gnt_id] : '0;

`ifdef FWA_BURST_LOCK_EN
  assign burst_done = in_last[gnt_id] || (beat_cnt == CW'(MAX_BURST - 1));
`else
  logic unused_last;
  assign unused_last = ^in_last;
  assign burst_done  = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= IDW'(N_REQ - 1);
      beat_cnt   <= '0;
      gnt_id     <= '0;
      gnt_valid  <= 1'b0;
      gnt_onehot <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state      <= BURST;
            gnt_id     <= pick_id;
            gnt_valid  <= 1'b1;
            gnt_onehot <= N_REQ'(1) << pick_id;
            beat_cnt   <= '0;
          end
        end
        BURST: begin
          // A dropped valid ends the grant; a stall (valid but full) keeps it.
          if (!cur_valid || (accept && burst_done)) begin
            state      <= IDLE;
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
            rr_ptr     <= gnt_id;
          end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter; expectations follow the FWA_BURST_LOCK_EN setting of the build.
module tb_fifo_write_arbiter;

  localparam int N_REQ     = 4;
  localparam int DSIZE     = 32;
  localparam int MAX_BURST = 4;
  localparam int IDW       = 2;
  localparam int TL        = 64;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N_REQ-1:0]       in_valid = '0;
  logic [N_REQ*DSIZE-1:0] in_data = '0;
  logic [N_REQ-1:0]       in_last = '0;
  logic [N_REQ-1:0]       in_ready;
  logic [DSIZE-1:0]       fifo_wdata;
  logic                   fifo_winc;
  logic                   fifo_wfull = 1'b0;
  logic                   gnt_valid;
  logic [IDW-1:0]         gnt_id;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.N_REQ(N_REQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .fifo_wdata(fifo_wdata), .fifo_winc(fifo_winc), .fifo_wfull(fifo_wfull),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id)
  );

  int errors = 0;
  int checks = 0;

  // Producer queues: one entry per beat, presented while en[i] is set.
  logic [DSIZE-1:0] q_data [N_REQ][32];
  logic             q_last [N_REQ][32];
  int               q_head [N_REQ];
  int               q_tail [N_REQ];
  logic [N_REQ-1:0] en;

  // Per-cycle trace and FIFO write log of the current scenario.
  logic             t_gv   [TL];
  logic [IDW-1:0]   t_gid  [TL];
  logic             t_winc [TL];
  logic [N_REQ-1:0] t_rdy  [TL];
  logic [DSIZE-1:0] wr_log [TL];
  int               wr_cnt;
  int               cyc;

  task automatic push(input int r, input logic [DSIZE-1:0] d, input logic l);
    if (q_tail[r] < 32) begin
      q_data[r][q_tail[r]] = d;
      q_last[r][q_tail[r]] = l;
      q_tail[r]++;
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N_REQ; i++) begin
      q_head[i] = 0;
      q_tail[i] = 0;
    end
    en = '0;
  endtask

  // Drive at the falling edge, sample 1 time unit later: the sample is what the next rising edge commits.
  task automatic step(input logic full_in, input logic rst_in);
    @(negedge clk);
    rst_n      = rst_in;
    fifo_wfull = full_in;
    for (int i = 0; i < N_REQ; i++) begin
      if (en[i] && q_head[i] < q_tail[i]) begin
        in_valid[i] = 1'b1;
        in_data[i*DSIZE +: DSIZE] = q_data[i][q_head[i]];
        in_last[i] = q_last[i][q_head[i]];
      end else begin
        in_valid[i] = 1'b0;
        in_data[i*DSIZE +: DSIZE] = '0;
        in_last[i] = 1'b0;
      end
    end
    #1;
    if (cyc < TL) begin
      t_gv[cyc]   = gnt_valid;
      t_gid[cyc]  = gnt_id;
      t_winc[cyc] = fifo_winc;
      t_rdy[cyc]  = in_ready;
    end
    if (fifo_winc) begin
      $display("cycle %0d: write data=%h gnt_id=%0d", cyc, fifo_wdata, gnt_id);
      if (wr_cnt < TL) wr_log[wr_cnt] = fifo_wdata;
      wr_cnt++;
    end
    for (int i = 0; i < N_REQ; i++)
      if (in_valid[i] && in_ready[i]) q_head[i]++;
    cyc++;
  endtask

  task automatic do_reset();
    clear_queues();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    cyc    = 0;
    wr_cnt = 0;
  endtask

  task automatic test_reset();
    clear_queues();
    for (int i = 0; i < N_REQ; i++) push(i, 32'h100 + i, 1'b1);
    en = '1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_gnt_valid got=%b want=0", gnt_valid); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt_id got=%0d want=0", gnt_id); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got=%b want=0000", in_ready); end
    checks++; if (fifo_winc !== 1'b0) begin errors++; $display("FAIL reset_winc got=%b want=0", fifo_winc); end
    checks++; if (fifo_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h want=0", fifo_wdata); end
  endtask

  task automatic test_single();
    logic [6:0] ew;
    do_reset();
    push(1, 32'hA0, 1'b0);
    push(1, 32'hA1, 1'b0);
    push(1, 32'hA2, 1'b1);
    en = 4'b0010;
    for (int k = 0; k < 7; k++) step(1'b0, 1'b1);
`ifdef FWA_BURST_LOCK_EN
    ew = 7'b0001110;
`else
    ew = 7'b0101010;
`endif
    checks++; if (t_gv[0] !== 1'b0) begin errors++; $display("FAIL single_gv0 got=%b want=0", t_gv[0]); end
    checks++; if (t_gv[1] !== 1'b1) begin errors++; $display("FAIL single_gv1 got=%b want=1", t_gv[1]); end
    checks++; if (t_gid[1] !== 2'd1) begin errors++; $display("FAIL single_gid1 got=%0d want=1", t_gid[1]); end
    checks++; if (t_gv[4] !== 1'b0) begin errors++; $display("FAIL single_gv4 got=%b want=0", t_gv[4]); end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (t_winc[k] !== ew[k]) begin errors++; $display("FAIL single_winc cycle=%0d got=%b want=%b", k, t_winc[k], ew[k]); end
    end
    checks++; if (wr_cnt !== 3) begin errors++; $display("FAIL single_count got=%0d want=3", wr_cnt); end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (wr_log[j] !== 32'hA0 + j) begin errors++; $display("FAIL single_data idx=%0d got=%h want=%h", j, wr_log[j], 32'hA0 + j); end
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < N_REQ; i++)
      for (int n = 0; n < 4; n++) push(i, 32'(i*16 + n), 1'b1);
    en = '1;
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (t_gv[k] !== k[0]) begin errors++; $display("FAIL fair_gv cycle=%0d got=%b want=%b", k, t_gv[k], k[0]); end
      if (k[0]) begin
        checks++;
        if (t_gid[k] !== IDW'(((k - 1) / 2) % 4)) begin
          errors++; $display("FAIL fair_gid cycle=%0d got=%0d want=%0d", k, t_gid[k], ((k - 1) / 2) % 4);
        end
      end
    end
    checks++; if (wr_cnt !== 6) begin errors++; $display("FAIL fair_count got=%0d want=6", wr_cnt); end
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (wr_log[j] !== 32'((j % 4)*16 + j/4)) begin
        errors++; $display("FAIL fair_data idx=%0d got=%h want=%h", j, wr_log[j], 32'((j % 4)*16 + j/4));
      end
    end
  endtask

  task automatic test_burst_cap();
    logic [DSIZE-1:0] exp_log [13];
    int exp_nb [16];
    int nb [16];
    int exp_ng;
    int ng;
    do_reset();
    push(0, 32'h00, 1'b1);
    for (int n = 0; n < 10; n++) push(2, 32'hC0 + n, n == 9);
    push(3, 32'h30, 1'b1);
    push(3, 32'h31, 1'b1);
    en = '1;
    for (int k = 0; k < 28; k++) step(1'b0, 1'b1);
    for (int j = 0; j < 16; j++) begin exp_nb[j] = 0; nb[j] = 0; end
`ifdef FWA_BURST_LOCK_EN
    exp_log = '{32'h00, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'h30, 32'hC4,
                32'hC5, 32'hC6, 32'hC7, 32'h31, 32'hC8, 32'hC9};
    exp_ng = 6;
    exp_nb[0] = 1; exp_nb[1] = 4; exp_nb[2] = 1; exp_nb[3] = 4; exp_nb[4] = 1; exp_nb[5] = 2;
`else
    exp_log = '{32'h00, 32'hC0, 32'h30, 32'hC1, 32'h31, 32'hC2, 32'hC3,
                32'hC4, 32'hC5, 32'hC6, 32'hC7, 32'hC8, 32'hC9};
    exp_ng = 13;
    for (int j = 0; j < 13; j++) exp_nb[j] = 1;
`endif
    ng = 0;
    for (int k = 0; k < 28; k++) begin
      if (t_gv[k] && (k == 0 || !t_gv[k-1])) ng++;
      if (t_gv[k] && t_winc[k] && ng > 0 && ng <= 16) nb[ng-1]++;
    end
    checks++; if (ng !== exp_ng) begin errors++; $display("FAIL cap_grants got=%0d want=%0d", ng, exp_ng); end
    for (int j = 0; j < exp_ng; j++) begin
      checks++;
      if (nb[j] !== exp_nb[j]) begin errors++; $display("FAIL cap_beats grant=%0d got=%0d want=%0d", j, nb[j], exp_nb[j]); end
    end
    checks++; if (wr_cnt !== 13) begin errors++; $display("FAIL cap_count got=%0d want=13", wr_cnt); end
    for (int j = 0; j < 13; j++) begin
      checks++;
      if (wr_log[j] !== exp_log[j]) begin errors++; $display("FAIL cap_data idx=%0d got=%h want=%h", j, wr_log[j], exp_log[j]); end
    end
  endtask

  task automatic test_stall();
    logic [12:0] ew;
    do_reset();
    for (int n = 0; n < 4; n++) push(1, 32'hB0 + n, n == 3);
    en = 4'b0010;
    for (int k = 0; k < 13; k++) step(k >= 2 && k <= 6, 1'b1);
`ifdef FWA_BURST_LOCK_EN
    ew = 13'b0001110000010;
`else
    ew = 13'b0101010000010;
`endif
    for (int k = 0; k < 13; k++) begin
      checks++;
      if (t_winc[k] !== ew[k]) begin errors++; $display("FAIL stall_winc cycle=%0d got=%b want=%b", k, t_winc[k], ew[k]); end
    end
    for (int k = 3; k <= 6; k++) begin
      checks++;
      if (t_gv[k] !== 1'b1 || t_gid[k] !== 2'd1 || t_rdy[k] !== 4'b0000) begin
        errors++; $display("FAIL stall_hold cycle=%0d gv=%b gid=%0d rdy=%b want gv=1 gid=1 rdy=0000", k, t_gv[k], t_gid[k], t_rdy[k]);
      end
    end
    checks++; if (t_rdy[7] !== 4'b0010) begin errors++; $display("FAIL stall_release got=%b want=0010", t_rdy[7]); end
    checks++; if (wr_cnt !== 4) begin errors++; $display("FAIL stall_count got=%0d want=4", wr_cnt); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (wr_log[j] !== 32'hB0 + j) begin errors++; $display("FAIL stall_data idx=%0d got=%h want=%h", j, wr_log[j], 32'hB0 + j); end
    end
  endtask

  task automatic test_valid_drop();
    logic [DSIZE-1:0] exp_log [7];
    int drop;
    do_reset();
    for (int n = 0; n < 5; n++) push(0, 32'hD0 + n, n == 4);
    push(1, 32'hE1, 1'b1);
    push(2, 32'hE2, 1'b1);
`ifdef FWA_BURST_LOCK_EN
    drop = 3;
    exp_log = '{32'hD0, 32'hD1, 32'hE1, 32'hE2, 32'hD2, 32'hD3, 32'hD4};
`else
    drop = 1;
    exp_log = '{32'hE1, 32'hE2, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hD4};
`endif
    for (int k = 0; k < 16; k++) begin
      en = (k == drop) ? 4'b0110 : 4'b0111;
      step(1'b0, 1'b1);
    end
    checks++;
    if (t_gv[drop] !== 1'b1 || t_gid[drop] !== 2'd0 || t_winc[drop] !== 1'b0) begin
      errors++; $display("FAIL drop_cycle gv=%b gid=%0d winc=%b want gv=1 gid=0 winc=0", t_gv[drop], t_gid[drop], t_winc[drop]);
    end
    checks++; if (t_gv[drop+1] !== 1'b0) begin errors++; $display("FAIL drop_end got=%b want=0", t_gv[drop+1]); end
    checks++; if (t_gid[drop+2] !== 2'd1) begin errors++; $display("FAIL drop_next got=%0d want=1", t_gid[drop+2]); end
    checks++; if (wr_cnt !== 7) begin errors++; $display("FAIL drop_count got=%0d want=7", wr_cnt); end
    for (int j = 0; j < 7; j++) begin
      checks++;
      if (wr_log[j] !== exp_log[j]) begin errors++; $display("FAIL drop_data idx=%0d got=%h want=%h", j, wr_log[j], exp_log[j]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int n = 0; n < 5; n++) push(2, 32'hF0 + n, n == 4);
    push(0, 32'h55, 1'b1);
    push(3, 32'h66, 1'b1);
    en = 4'b0100;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    checks++; if (t_gv[3] !== 1'b1 || t_gid[3] !== 2'd2) begin errors++; $display("FAIL rmid_pre gv=%b gid=%0d want gv=1 gid=2", t_gv[3], t_gid[3]); end
    en = 4'b1101;
    step(1'b0, 1'b1);
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL rmid_gv got=%b want=0", gnt_valid); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL rmid_gid got=%0d want=0", gnt_id); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rmid_ready got=%b want=0000", in_ready); end
    checks++; if (fifo_winc !== 1'b0 || fifo_wdata !== 32'h0) begin errors++; $display("FAIL rmid_fifo winc=%b data=%h want 0/0", fifo_winc, fifo_wdata); end
    step(1'b0, 1'b1);
    checks++; if (gnt_valid !== 1'b1 || gnt_id !== 2'd0) begin errors++; $display("FAIL rmid_first gv=%b gid=%0d want gv=1 gid=0", gnt_valid, gnt_id); end
    checks++; if (fifo_winc !== 1'b1 || fifo_wdata !== 32'h55) begin errors++; $display("FAIL rmid_beat winc=%b data=%h want 1/55", fifo_winc, fifo_wdata); end
  endtask

  initial begin
    cyc    = 0;
    wr_cnt = 0;
    test_reset();
    test_single();
    test_fairness();
    test_burst_cap();
    test_stall();
    test_valid_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
